// File: rtl/alu_pkg.sv
// Shared encodings for the ALU execute unit: control codes, alu_op classes,
// FSM states and the M-extension funct7 marker.
package alu_pkg;

  localparam logic [3:0] ALU_ADD     = 4'b0000;
  localparam logic [3:0] ALU_SUB     = 4'b0001;
  localparam logic [3:0] ALU_AND     = 4'b0010;
  localparam logic [3:0] ALU_OR      = 4'b0011;
  localparam logic [3:0] ALU_XOR     = 4'b0100;
  localparam logic [3:0] ALU_SLT     = 4'b0101;
  localparam logic [3:0] ALU_SLL     = 4'b0110;
  localparam logic [3:0] ALU_SRL     = 4'b0111;
  localparam logic [3:0] ALU_SRA     = 4'b1000;
  localparam logic [3:0] ALU_SLTU    = 4'b1001;
  localparam logic [3:0] ALU_MUL     = 4'b1010;
  localparam logic [3:0] ALU_MULHU   = 4'b1011;
  localparam logic [3:0] ALU_DIVU    = 4'b1100;
  localparam logic [3:0] ALU_REMU    = 4'b1101;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_exec_unit_mdu.sv
// Iterative radix-2 multiply (shift-add) and restoring divide engine.
// hi/lo present the accumulator value after the current iteration, so they are final while done is high.
module alu_mdu_iter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_div,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam logic [SHAMT_W:0] LAST_ITER = (SHAMT_W+1)'(XLEN - 1);

  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_nxt;
  logic [XLEN-1:0]   opd;
  logic              div_mode;
  logic              running;
  logic [SHAMT_W:0]  cnt;
  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     diff;

  // Divide: shifted partial remainder needs XLEN+1 bits; the borrow bit picks restore vs. subtract.
  always_comb begin
    add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opd};
    rem_sh  = acc[2*XLEN-1:XLEN-1];
    diff    = rem_sh - {1'b0, opd};
    if (div_mode) begin
      if (!diff[XLEN]) acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else             acc_nxt = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else if (acc[0]) begin
      acc_nxt = {add_sum, acc[XLEN-1:1]};
    end else begin
      acc_nxt = {1'b0, acc[2*XLEN-1:1]};
    end
  end

  assign done = running && (cnt == LAST_ITER);
  assign hi   = acc_nxt[2*XLEN-1:XLEN];
  assign lo   = acc_nxt[XLEN-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      opd      <= '0;
      div_mode <= 1'b0;
      running  <= 1'b0;
      cnt      <= '0;
    end else if (start) begin
      acc      <= {{XLEN{1'b0}}, a};
      opd      <= b;
      div_mode <= is_div;
      running  <= 1'b1;
      cnt      <= '0;
    end else if (running) begin
      acc <= acc_nxt;
      cnt <= cnt + (SHAMT_W+1)'(1);
      if (cnt == LAST_ITER) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute unit: decodes alu_op/funct fields, runs single-cycle ops directly
// and hands MUL/MULHU/DIVU/REMU to the iterative engine.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = $clog2(XLEN),
  parameter int unsigned CTRL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [6:0]        opcode,
  input  logic [XLEN-1:0]   src_a,
  input  logic [XLEN-1:0]   src_b,
  output logic              out_valid,
  output logic [XLEN-1:0]   result,
  output logic              zero,
  output logic              illegal,
  output logic              busy,
  output logic [CTRL_W-1:0] alu_cntl
);

  alu_state_e        state, state_nxt;
  logic [3:0]        cntl_dec;
  logic [3:0]        cntl_q;
  logic [XLEN-1:0]   sc_res;
  logic [XLEN-1:0]   mdu_res;
  logic [XLEN-1:0]   mdu_hi, mdu_lo;
  logic [SHAMT_W-1:0] shamt;
  logic              accept, is_mul_op, is_div_op, mdu_start, mdu_done;
  logic              unused_opcode_bits;

  assign unused_opcode_bits = ^{opcode[6], opcode[4:0]};

  always_comb begin
    cntl_dec = ALU_ILLEGAL;
    case (alu_op)
      ALUOP_ADD: cntl_dec = ALU_ADD;
      ALUOP_SUB: cntl_dec = ALU_SUB;
      ALUOP_FUNCT: begin
        if (funct7 == FUNCT7_MEXT && opcode[5]) begin
          case (funct3)
            3'b000:  cntl_dec = ALU_MUL;
            3'b011:  cntl_dec = ALU_MULHU;
            3'b101:  cntl_dec = ALU_DIVU;
            3'b111:  cntl_dec = ALU_REMU;
            default: cntl_dec = ALU_ILLEGAL;
          endcase
        end else begin
          case (funct3)
            3'b000:  cntl_dec = (opcode[5] && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  cntl_dec = ALU_SLL;
            3'b010:  cntl_dec = ALU_SLT;
            3'b011:  cntl_dec = ALU_SLTU;
            3'b100:  cntl_dec = ALU_XOR;
            3'b101:  cntl_dec = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  cntl_dec = ALU_OR;
            default: cntl_dec = ALU_AND;
          endcase
        end
      end
      default: cntl_dec = ALU_ILLEGAL;
    endcase
  end

  // DIVU/REMU only reach this path with a zero divisor.
  always_comb begin
    shamt = src_b[SHAMT_W-1:0];
    case (cntl_dec)
      ALU_ADD:  sc_res = src_a + src_b;
      ALU_SUB:  sc_res = src_a - src_b;
      ALU_AND:  sc_res = src_a & src_b;
      ALU_OR:   sc_res = src_a | src_b;
      ALU_XOR:  sc_res = src_a ^ src_b;
      ALU_SLT:  sc_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_SLTU: sc_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      ALU_SLL:  sc_res = src_a << shamt;
      ALU_SRL:  sc_res = src_a >> shamt;
      ALU_SRA:  sc_res = $unsigned($signed(src_a) >>> shamt);
      ALU_DIVU: sc_res = '1;
      ALU_REMU: sc_res = src_a;
      default:  sc_res = '0;
    endcase
  end

  assign accept    = in_valid && (state == ST_IDLE);
  assign is_mul_op = (cntl_dec == ALU_MUL) || (cntl_dec == ALU_MULHU);
  assign is_div_op = ((cntl_dec == ALU_DIVU) || (cntl_dec == ALU_REMU)) && (src_b != '0);
  assign mdu_start = accept && (is_mul_op || is_div_op);
  assign mdu_res   = ((cntl_q == ALU_MUL) || (cntl_q == ALU_DIVU)) ? mdu_lo : mdu_hi;

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign alu_cntl = CTRL_W'(cntl_q);

  alu_mdu_iter #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_mdu (
    .clk    (clk),
    .rst    (rst),
    .start  (mdu_start),
    .is_div (is_div_op),
    .a      (src_a),
    .b      (src_b),
    .done   (mdu_done),
    .hi     (mdu_hi),
    .lo     (mdu_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (mdu_start) state_nxt = is_mul_op ? ST_MUL : ST_DIV;
      ST_MUL, ST_DIV: if (mdu_done) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
      cntl_q    <= ALU_ADD;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        cntl_q <= cntl_dec;
        if (!mdu_start) begin
          out_valid <= 1'b1;
          result    <= sc_res;
          zero      <= (sc_res == '0);
          illegal   <= (cntl_dec == ALU_ILLEGAL);
        end
      end else if (mdu_done && state != ST_IDLE) begin
        out_valid <= 1'b1;
        result    <= mdu_res;
        zero      <= (mdu_res == '0);
        illegal   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit with hand-computed expectations.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [6:0]  opcode;
  logic [31:0] src_a, src_b;
  logic        out_valid;
  logic [31:0] result;
  logic        zero, illegal, busy;
  logic [3:0]  alu_cntl;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] F7_A  = 7'b0100000;
  localparam logic [6:0] F7_M  = 7'b0000001;

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [6:0]  opc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic [3:0]  cntl;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  alu_exec_unit #(
    .XLEN    (32),
    .SHAMT_W (5),
    .CTRL_W  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct3    (funct3),
    .funct7    (funct7),
    .opcode    (opcode),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal),
    .busy      (busy),
    .alu_cntl  (alu_cntl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [6:0] opc, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp, input logic [3:0] cntl, input logic ill,
                              input int lat);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.opc = opc; v.a = a; v.b = b;
    v.exp = exp; v.cntl = cntl; v.ill = ill; v.lat = lat;
    return v;
  endfunction

  // Issue one op from IDLE, wait (bounded) for out_valid, then check it was a single pulse.
  task automatic run_vec(input vec_t v, input int idx);
    int    lat;
    int    busy_n;
    int    nrdy_n;
    string t;
    t = $sformatf("v%0d", idx);
    alu_op = v.op; funct3 = v.f3; funct7 = v.f7; opcode = v.opc;
    src_a = v.a; src_b = v.b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    src_a = ~v.a; src_b = ~v.b;
    lat = 1; busy_n = 0; nrdy_n = 0;
    while (!out_valid && lat < 100) begin
      if (busy) busy_n++;
      if (!in_ready) nrdy_n++;
      @(posedge clk); #1;
      lat++;
    end
    check({t, " latency"}, 32'(lat), 32'(v.lat));
    check({t, " result"}, result, v.exp);
    check({t, " zero"}, {31'd0, zero}, {31'd0, v.exp == 32'd0});
    check({t, " illegal"}, {31'd0, illegal}, {31'd0, v.ill});
    check({t, " alu_cntl"}, {28'd0, alu_cntl}, {28'd0, v.cntl});
    check({t, " busy cycles"}, 32'(busy_n), 32'(v.lat - 1));
    check({t, " not-ready cycles"}, 32'(nrdy_n), 32'(v.lat - 1));
    @(posedge clk); #1;
    check({t, " pulse"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int          ovc;
    logic [31:0] res_seen;

    rst = 1'b1; in_valid = 1'b0; alu_op = 2'b00; funct3 = 3'b000;
    funct7 = 7'd0; opcode = OPC_R; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst result", result, 32'd0);
    check("rst zero", {31'd0, zero}, 32'd0);
    check("rst illegal", {31'd0, illegal}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst in_ready", {31'd0, in_ready}, 32'd1);
    check("rst alu_cntl", {28'd0, alu_cntl}, 32'd0);

    vecs.push_back(mk(2'b10, 3'b000, F7_A,  OPC_R, 32'd5, 32'd7, 32'hFFFF_FFFE, 4'h1, 1'b0, 1));
    vecs.push_back(mk(2'b10, 3'b000, F7_A,  OPC_I, 32'd5, 32'd7, 32'd12,        4'h0, 1'b0, 1));
    vecs.push_back(mk(2'b00, 3'b111, F7_A,  OPC_R, 32'd3, 32'd4, 32'd7,         4'h0, 1'b0, 1));
    vecs.push_back(mk(2'b01, 3'b000, 7'd0,  OPC_R, 32'd5, 32'd5, 32'd0,         4'h1, 1'b0, 1));
    vecs.push_back(mk(2'b10, 3'b101, F7_A,  OPC_I, 32'h8000_0000, 32'h24, 32'hF800_0000, 4'h8, 1'b0, 1));
    vecs.push_back(mk(2'b10, 3'b101, 7'd0,  OPC_I, 32'h8000_0000, 32'h24, 32'h0800_0000, 4'h7, 1'b0, 1));
    vecs.push_back(mk(2'b10, 3'b001, 7'd0,  OPC_R, 32'd1, 32'h21, 32'd2,        4'h6, 1'b0, 1));
    vecs.push_back(mk(2'b10, 3'b010, 7'd0,  OPC_R, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'h5, 1'b0, 1));
    vecs.push_back(mk(2'b10, 3'b011, 7'd0,  OPC_R, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'h9, 1'b0, 1));
    vecs.push_back(mk(2'b10, 3'b100, 7'd0,  OPC_R, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'h4, 1'b0, 1));
    vecs.push_back(mk(2'b10, 3'b110, 7'd0,  OPC_R, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 4'h3, 1'b0, 1));
    vecs.push_back(mk(2'b10, 3'b111, 7'd0,  OPC_R, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'h2, 1'b0, 1));
    vecs.push_back(mk(2'b10, 3'b000, F7_M,  OPC_R, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 4'hA, 1'b0, 33));
    vecs.push_back(mk(2'b10, 3'b011, F7_M,  OPC_R, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 4'hB, 1'b0, 33));
    vecs.push_back(mk(2'b10, 3'b101, F7_M,  OPC_R, 32'd100, 32'd7, 32'd14,      4'hC, 1'b0, 33));
    vecs.push_back(mk(2'b10, 3'b111, F7_M,  OPC_R, 32'd100, 32'd7, 32'd2,       4'hD, 1'b0, 33));
    vecs.push_back(mk(2'b10, 3'b101, F7_M,  OPC_R, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 4'hC, 1'b0, 33));
    vecs.push_back(mk(2'b10, 3'b111, F7_M,  OPC_R, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 4'hD, 1'b0, 33));
    vecs.push_back(mk(2'b10, 3'b101, F7_M,  OPC_R, 32'd9, 32'd0, 32'hFFFF_FFFF, 4'hC, 1'b0, 1));
    vecs.push_back(mk(2'b10, 3'b111, F7_M,  OPC_R, 32'd9, 32'd0, 32'd9,         4'hD, 1'b0, 1));
    vecs.push_back(mk(2'b10, 3'b001, F7_M,  OPC_R, 32'd6, 32'd7, 32'd0,         4'hF, 1'b1, 1));
    vecs.push_back(mk(2'b11, 3'b000, 7'd0,  OPC_R, 32'd6, 32'd7, 32'd0,         4'hF, 1'b1, 1));
    vecs.push_back(mk(2'b10, 3'b000, F7_M,  OPC_I, 32'd2, 32'd3, 32'd5,         4'h0, 1'b0, 1));

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset in the middle of a divide.
    alu_op = 2'b10; funct3 = 3'b101; funct7 = F7_M; opcode = OPC_R;
    src_a = 32'd100; src_b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort out_valid", {31'd0, out_valid}, 32'd0);
    check("abort result", result, 32'd0);
    check("abort in_ready", {31'd0, in_ready}, 32'd1);
    run_vec(mk(2'b00, 3'b000, 7'd0, OPC_R, 32'd3, 32'd4, 32'd7, 4'h0, 1'b0, 1), 100);
    ovc = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) ovc++;
      @(posedge clk); #1;
    end
    check("abort stray out_valid", 32'(ovc), 32'd0);

    // in_valid pulses while busy must be ignored.
    alu_op = 2'b10; funct3 = 3'b000; funct7 = F7_M; opcode = OPC_R;
    src_a = 32'd3; src_b = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ovc = 0; res_seen = '0;
    for (int c = 1; c <= 50; c++) begin
      if (out_valid) begin
        ovc++;
        res_seen = result;
      end
      if (c >= 5 && c <= 20) begin
        in_valid = c[0];
        alu_op = 2'b00; src_a = 32'(c); src_b = 32'd1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    check("busy-ignore out_valid count", 32'(ovc), 32'd1);
    check("busy-ignore result", res_seen, 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised successor to the core's combinational ALU decoder: decodes alu_op/funct3/funct7/opcode into a 4-bit ALU control and executes the operation on XLEN-bit operands.
- Covers the full RV32I arithmetic/logic/shift set plus unsigned RV32M MUL, MULHU, DIVU and REMU.
- Single-cycle ops return a registered result after 1 cycle. Multiply and divide run on an iterative radix-2 engine; the core stalls fetch while busy is high.

Parameters:
- XLEN, 32, operand/result width; power of two, at least 8.
- SHAMT_W, $clog2(XLEN), shift-amount width taken from src_b[SHAMT_W-1:0].
- CTRL_W, 4, width of the alu_cntl encoding.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation request; accepted when in_ready is 1
- in_ready  out  1  high only in IDLE
- alu_op  in  2  00 ADD, 01 SUB (branch compare), 10 decode funct fields, 11 reserved
- funct3  in  3  instruction funct3
- funct7  in  7  instruction funct7
- opcode  in  7  instruction opcode; bit 5 = register-register form
- src_a  in  XLEN  operand A
- src_b  in  XLEN  operand B (register or immediate)
- out_valid  out  1  one-cycle pulse; result, zero and illegal are valid
- result  out  XLEN  operation result; held until the next out_valid
- zero  out  1  result == 0; qualified by out_valid
- illegal  out  1  unsupported decode; qualified by out_valid
- busy  out  1  multi-cycle operation in progress
- alu_cntl  out  CTRL_W  decoded control of the accepted op; registered for debug

Behaviour:
- Reset: state IDLE; in_ready=1 (combinational from state); out_valid=0, result=0, zero=0, illegal=0, busy=0, alu_cntl=0. A reset during MUL/DIV aborts the operation and discards the partial result.
- Encoding (in alu_pkg): 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLL, 0111 SRL, 1000 SRA, 1001 SLTU, 1010 MUL, 1011 MULHU, 1100 DIVU, 1101 REMU, 1111 ILLEGAL.
- Decode for alu_op 00 and 01: ADD and SUB respectively.
- Decode for alu_op 10 with funct7==0000001 and opcode[5]=1: funct3 000 MUL, 011 MULHU, 101 DIVU, 111 REMU; any other funct3 is ILLEGAL.
- Decode for alu_op 10, all other cases:
  - funct3 000: SUB if opcode[5]&funct7[5], else ADD.
  - 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 110 OR; 111 AND.
  - 101: SRA if funct7[5], else SRL.
- Decode for alu_op 11: ILLEGAL.
- Arithmetic rules:
  - ADD and SUB wrap modulo 2^XLEN.
  - SLT is a signed compare, SLTU unsigned; both return {XLEN-1 zeros, flag}.
  - Shifts use src_b[SHAMT_W-1:0] only.
- FSM states: IDLE, MUL, DIV.
- IDLE, in_valid=1, single-cycle or ILLEGAL op: compute and register. out_valid=1 on the next cycle (latency 1); stay in IDLE, so back-to-back issue is possible. ILLEGAL returns result=0, illegal=1.
- IDLE, in_valid=1, MUL/MULHU: load multiplicand/multiplier into a 2*XLEN accumulator and go to MUL; busy=1, in_ready=0.
  - Shift-add, one bit per cycle, for XLEN cycles, then return to IDLE with out_valid=1. Latency from accept to out_valid is XLEN+1.
  - MUL returns the low half, MULHU the high half.
- IDLE, in_valid=1, DIVU/REMU with src_b != 0: go to DIV; restoring division, XLEN iterations; same latency and handshake as MUL. DIVU returns the quotient, REMU the remainder.
- Divide by zero: no iteration, latency 1, in_ready stays 1. DIVU returns all ones; REMU returns src_a.
- in_valid while busy is ignored: the operation is not queued, and the requester holds in_valid.
- Operands are captured at accept; src changes after accept have no effect.
- out_valid has no backpressure.
- zero is computed on the final registered result.

Decomposition:
- alu_pkg: ALU_CNTL localparams, ALU_OP codes (00/01/10/11), FSM state encodings, funct7 M-extension constant 0000001.
- Sub-module alu_mdu_iter holds the iterative mul/div datapath:
  - inputs: start, is_div, a, b
  - outputs: done, hi, lo
  - contents: accumulator, iteration counter of width SHAMT_W+1.
- Decode and single-cycle datapath stay in alu_exec_unit.

Test Plan:
- alu_op=10, funct3=000, opcode=0110011, funct7=0100000, a=5, b=7 -> next cycle out_valid=1, result=0xFFFFFFFE, zero=0, alu_cntl=0001.
- alu_op=10, funct3=101, funct7=0100000, a=0x80000000, b=0x24 (shamt 4) -> result=0xF8000000 (SRA); same with funct7=0 -> 0x08000000 (SRL).
- MUL a=0xFFFFFFFF, b=2; then MULHU with the same operands:
  - each: busy=1 for 32 cycles, in_ready=0, out_valid at cycle 33 after accept;
  - MUL result=0xFFFFFFFE, MULHU result=0x00000001.
- DIVU a=100, b=7 -> result=14 after 33 cycles; REMU -> 2; DIVU a=9, b=0 -> result=0xFFFFFFFF after 1 cycle; REMU a=9, b=0 -> 9.
- Start DIVU; assert rst at iteration 10 -> next cycle: state IDLE, busy=0, out_valid=0, result=0; a new ADD 3+4 issued afterwards returns 7.
- alu_op=10, funct7=0000001, funct3=001 (MULH) -> illegal=1, result=0; alu_op=11 -> illegal=1; in_valid pulses during busy are ignored, and exactly one out_valid is produced per accepted op.
